// File: rtl/rtl_settings_pkg.sv
// Shared AMM widths and the memory-slave state type used across the checker's RTL.
package rtl_settings_pkg;

    localparam int AMM_ADDR_W            = 32;
    localparam int AMM_DATA_W            = 512;
    localparam int AMM_BURST_W           = 11;
    localparam int DATA_B_W              = AMM_DATA_W / 8;
    localparam int ADDR_B_W              = $clog2(DATA_B_W);
    localparam int AMM_SLAVE_RD_LATENCY  = 2;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST
    } amm_slave_state_t;

    // Statistic counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/amm_slave_ram.sv
// Single-port byte-lane RAM with a registered read port; one narrow array per lane
// so each lane maps onto block RAM with its own write enable.
module amm_slave_ram #(
    parameter int DATA_W  = 512,
    parameter int DEPTH_W = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_W-1:0]    addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : gen_lane
            logic [7:0] mem [0:(1 << DEPTH_W) - 1];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    rd_reg <= mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/amm_mem_slave.sv
// Avalon-MM burst slave backed by a byte-enabled RAM with fixed read latency; stands in
// for the external memory controller so checker results are fully deterministic.
module amm_mem_slave #(
    parameter int AMM_ADDR_W  = rtl_settings_pkg::AMM_ADDR_W,
    parameter int AMM_DATA_W  = rtl_settings_pkg::AMM_DATA_W,
    parameter int AMM_BURST_W = rtl_settings_pkg::AMM_BURST_W,
    parameter int MEM_DEPTH_W = 10,
    parameter int RD_LATENCY  = rtl_settings_pkg::AMM_SLAVE_RD_LATENCY
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AMM_ADDR_W-1:0]     amm_address_i,
    input  logic                      amm_read_i,
    input  logic                      amm_write_i,
    input  logic [AMM_DATA_W-1:0]     amm_writedata_i,
    input  logic [AMM_DATA_W/8-1:0]   amm_byteenable_i,
    input  logic [AMM_BURST_W-1:0]    amm_burstcount_i,
    output logic                      amm_waitrequest_o,
    output logic [AMM_DATA_W-1:0]     amm_readdata_o,
    output logic                      amm_readdatavalid_o,
    output logic [31:0]               wr_words_o,
    output logic [31:0]               rd_words_o,
    output logic                      protocol_err_o
);

    import rtl_settings_pkg::*;

    localparam int LANE_SHIFT = $clog2(AMM_DATA_W / 8);

    amm_slave_state_t         state_reg, state_next;
    logic [MEM_DEPTH_W-1:0]   idx_reg, idx_next;
    logic [AMM_BURST_W-1:0]   left_reg, left_next;
    logic                     wait_init_reg;
    logic                     perr_reg;
    logic [31:0]              wr_words_reg, rd_words_reg;
    logic [RD_LATENCY-1:0]    vld_reg;

    logic                     ram_we, ram_re, perr_set;
    logic [MEM_DEPTH_W-1:0]   ram_addr, cmd_idx;
    logic [AMM_BURST_W-1:0]   cmd_len;
    logic [AMM_DATA_W-1:0]    ram_rdata;
    logic                     addr_unused;

    assign cmd_idx     = amm_address_i[LANE_SHIFT +: MEM_DEPTH_W];
    assign cmd_len     = (amm_burstcount_i == '0) ? AMM_BURST_W'(1) : amm_burstcount_i;
    assign addr_unused = ^amm_address_i;

    // Held high through reset and released one clock later, then only for read bursts.
    assign amm_waitrequest_o = wait_init_reg | (state_reg == RD_BURST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            left_reg      <= '0;
            wait_init_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            left_reg      <= left_next;
            wait_init_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        left_next  = left_reg;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = idx_reg;
        perr_set   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!wait_init_reg) begin
                    if (amm_write_i) begin
                        // A simultaneous read is dropped; the write wins.
                        ram_we    = 1'b1;
                        ram_addr  = cmd_idx;
                        idx_next  = cmd_idx + MEM_DEPTH_W'(1);
                        left_next = cmd_len - AMM_BURST_W'(1);
                        perr_set  = amm_read_i;
                        if (cmd_len != AMM_BURST_W'(1)) begin
                            state_next = WR_BURST;
                        end
                    end else if (amm_read_i) begin
                        ram_re    = 1'b1;
                        ram_addr  = cmd_idx;
                        idx_next  = cmd_idx + MEM_DEPTH_W'(1);
                        left_next = cmd_len - AMM_BURST_W'(1);
                        if (cmd_len != AMM_BURST_W'(1)) begin
                            state_next = RD_BURST;
                        end
                    end
                end
            end
            WR_BURST: begin
                perr_set = amm_read_i;
                if (amm_write_i) begin
                    ram_we    = 1'b1;
                    idx_next  = idx_reg + MEM_DEPTH_W'(1);
                    left_next = left_reg - AMM_BURST_W'(1);
                    if (left_reg == AMM_BURST_W'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            RD_BURST: begin
                ram_re    = 1'b1;
                idx_next  = idx_reg + MEM_DEPTH_W'(1);
                left_next = left_reg - AMM_BURST_W'(1);
                if (left_reg == AMM_BURST_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    amm_slave_ram #(
        .DATA_W  (AMM_DATA_W),
        .DEPTH_W (MEM_DEPTH_W)
    ) u_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (amm_writedata_i),
        .be    (amm_byteenable_i),
        .rdata (ram_rdata)
    );

    // Valid rides alongside data; stage 0 lines up with the RAM's registered output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_reg <= '0;
        end else begin
            vld_reg[0] <= ram_re;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_reg[i] <= vld_reg[i-1];
            end
        end
    end

    assign amm_readdatavalid_o = vld_reg[RD_LATENCY-1];

    generate
        if (RD_LATENCY == 1) begin : gen_direct
            // RAM output only moves on a read, so it already holds; mask it until the first read after reset.
            logic seen_reg;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    seen_reg <= 1'b0;
                end else if (vld_reg[0]) begin
                    seen_reg <= 1'b1;
                end
            end
            assign amm_readdata_o = seen_reg ? ram_rdata : '0;
        end else begin : gen_pipe
            logic [AMM_DATA_W-1:0] data_pipe_reg [RD_LATENCY-1];
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < RD_LATENCY - 1; i++) begin
                        data_pipe_reg[i] <= '0;
                    end
                end else begin
                    if (vld_reg[0]) begin
                        data_pipe_reg[0] <= ram_rdata;
                    end
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        if (vld_reg[i]) begin
                            data_pipe_reg[i] <= data_pipe_reg[i-1];
                        end
                    end
                end
            end
            assign amm_readdata_o = data_pipe_reg[RD_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_words_reg <= '0;
            rd_words_reg <= '0;
            perr_reg     <= 1'b0;
        end else begin
            if (ram_we) begin
                wr_words_reg <= sat_inc32(wr_words_reg);
            end
            if (vld_reg[RD_LATENCY-1]) begin
                rd_words_reg <= sat_inc32(rd_words_reg);
            end
            if (perr_set) begin
                perr_reg <= 1'b1;
            end
        end
    end

    assign wr_words_o     = wr_words_reg;
    assign rd_words_o     = rd_words_reg;
    assign protocol_err_o = perr_reg;

endmodule

// File: tb/tb_amm_mem_slave.sv
// Scoreboard bench for amm_mem_slave: driver pushes expected read words from an array
// memory model, a negedge monitor pops and compares data and arrival cycle.
module tb_amm_mem_slave;

    localparam int DW    = 512;
    localparam int BW    = 64;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     address;
    logic            read, write;
    logic [DW-1:0]   wdata;
    logic [BW-1:0]   be;
    logic [10:0]     burst;
    logic            waitreq;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;
    logic [31:0]     wr_words, rd_words;
    logic            perr;

    amm_mem_slave #(
        .MEM_DEPTH_W (4),
        .RD_LATENCY  (LAT)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .amm_address_i       (address),
        .amm_read_i          (read),
        .amm_write_i         (write),
        .amm_writedata_i     (wdata),
        .amm_byteenable_i    (be),
        .amm_burstcount_i    (burst),
        .amm_waitrequest_o   (waitreq),
        .amm_readdata_o      (readdata),
        .amm_readdatavalid_o (readdatavalid),
        .wr_words_o          (wr_words),
        .rd_words_o          (rd_words),
        .protocol_err_o      (perr)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            exp_cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mem_m [DEPTH];
    int            m_wr = 0;
    int            m_rd = 0;
    bit            m_perr = 1'b0;
    logic [DW-1:0] beat_data [DEPTH];
    logic [BW-1:0] beat_be   [DEPTH];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Only address bits [9:6] select the word; the rest is noise the slave must ignore.
    function automatic logic [31:0] mk_addr(input int word);
        logic [31:0] a;
        a      = $urandom;
        a[9:6] = word[3:0];
        return a;
    endfunction

    task automatic model_write(input int idx, input logic [DW-1:0] d, input logic [BW-1:0] b);
        for (int i = 0; i < BW; i++) begin
            if (b[i]) mem_m[idx][i*8 +: 8] = d[i*8 +: 8];
        end
    endtask

    // Monitor: every readdatavalid must match the oldest expectation, on its exact cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].exp_cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_missing: no readdatavalid at cycle %0d, expected data %0h", exp_q[0].exp_cyc, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (readdatavalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: readdatavalid=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_cycle", DW'(cyc), DW'(e.exp_cyc));
                    check("rd_data", readdata, e.data);
                end
            end
        end
    end

    task automatic wait_accept(output int acc);
        acc = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!waitreq) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: waitrequest still 1 after 200 cycles, expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input int word, input int n, input bit with_read, input int max_gap);
        int n_eff;
        int acc;
        n_eff   = (n == 0) ? 1 : n;
        address = mk_addr(word);
        burst   = 11'(n);
        for (int k = 0; k < n_eff; k++) begin
            if (k > 0 && max_gap > 0) begin
                write = 1'b0;
                read  = 1'b0;
                repeat ($urandom_range(max_gap, 0)) begin
                    @(posedge clk);
                    #1;
                end
            end
            write = 1'b1;
            read  = (k == 0) && with_read;
            wdata = beat_data[k];
            be    = beat_be[k];
            wait_accept(acc);
            if (acc >= 0) begin
                model_write((word + k) % DEPTH, beat_data[k], beat_be[k]);
                m_wr++;
                if (k == 0 && with_read) m_perr = 1'b1;
            end
        end
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic read_burst(input int word, input int n, input bit chk_wait);
        int   n_eff;
        int   acc;
        exp_t e;
        n_eff   = (n == 0) ? 1 : n;
        address = mk_addr(word);
        burst   = 11'(n);
        read    = 1'b1;
        wait_accept(acc);
        read    = 1'b0;
        if (acc >= 0) begin
            for (int k = 0; k < n_eff; k++) begin
                e.data    = mem_m[(word + k) % DEPTH];
                e.exp_cyc = acc + LAT + k;
                exp_q.push_back(e);
                m_rd++;
            end
            if (chk_wait) begin
                for (int k = 1; k < n_eff; k++) begin
                    @(negedge clk);
                    check("waitreq_busy", DW'(waitreq), DW'(1));
                end
                @(negedge clk);
                check("waitreq_free", DW'(waitreq), DW'(0));
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 64 && exp_q.size() > 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats();
        @(negedge clk);
        check("wr_words", DW'(wr_words), DW'(m_wr));
        check("rd_words", DW'(rd_words), DW'(m_rd));
        check("protocol_err", DW'(perr), DW'(m_perr));
        @(posedge clk);
        #1;
    endtask

    initial begin
        read    = 1'b0;
        write   = 1'b0;
        address = '0;
        wdata   = '0;
        be      = '0;
        burst   = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_waitreq", DW'(waitreq), DW'(1));
        check("rst_valid", DW'(readdatavalid), DW'(0));
        check("rst_readdata", readdata, '0);
        check("rst_wr_words", DW'(wr_words), DW'(0));
        check("rst_rd_words", DW'(rd_words), DW'(0));
        check("rst_perr", DW'(perr), DW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("release_waitreq", DW'(waitreq), DW'(0));
        @(posedge clk);
        #1;

        // Write A0..A3 at byte address 0x40, read them back
        for (int k = 0; k < 4; k++) begin
            beat_data[k] = DW'(32'hA0 + k);
            beat_be[k]   = '1;
        end
        write_burst(1, 4, 1'b0, 0);
        read_burst(1, 4, 1'b1);
        drain();
        check_stats();

        // Fill the whole memory so every later read has a defined expectation
        for (int k = 0; k < DEPTH; k++) begin
            beat_data[k] = rand_word();
            beat_be[k]   = '1;
        end
        write_burst(0, DEPTH, 1'b0, 1);

        // Byte-lane merge on word 5
        beat_data[0] = '1;
        beat_be[0]   = '1;
        write_burst(5, 1, 1'b0, 0);
        beat_data[0] = '0;
        beat_be[0]   = 64'h1;
        write_burst(5, 1, 1'b0, 0);
        read_burst(5, 1, 1'b0);
        drain();

        // Burst wrapping past the top index
        for (int k = 0; k < 3; k++) begin
            beat_data[k] = rand_word();
            beat_be[k]   = '1;
        end
        write_burst(15, 3, 1'b0, 1);
        read_burst(15, 3, 1'b1);
        drain();

        // Randomised mixed traffic, back-to-back where the handshake allows
        for (int it = 0; it < 40; it++) begin
            int word;
            int n;
            word = $urandom_range(DEPTH - 1, 0);
            n    = $urandom_range(5, 0);
            if ($urandom_range(1, 0) == 1) begin
                for (int k = 0; k < DEPTH; k++) begin
                    beat_data[k] = rand_word();
                    beat_be[k]   = {$urandom, $urandom};
                end
                write_burst(word, n, 1'b0, 2);
            end else begin
                read_burst(word, n, 1'b0);
            end
        end
        drain();
        check_stats();

        // Read and write together: write stored, read dropped, sticky error
        beat_data[0] = rand_word();
        beat_be[0]   = '1;
        write_burst(7, 1, 1'b1, 0);
        drain();
        read_burst(7, 1, 1'b0);
        read_burst(3, 2, 1'b0);
        drain();
        check_stats();

        // Reset three cycles into an 8-word read burst
        begin
            int acc;
            exp_t e;
            address = mk_addr(0);
            burst   = 11'd8;
            read    = 1'b1;
            wait_accept(acc);
            read    = 1'b0;
            for (int k = 0; k < 8; k++) begin
                e.data    = mem_m[k % DEPTH];
                e.exp_cyc = acc + LAT + k;
                exp_q.push_back(e);
            end
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            exp_q.delete();
            m_wr   = 0;
            m_rd   = 0;
            m_perr = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (12) @(posedge clk);
            #1;
            check_stats();
        end

        // Single read after the abort returns in exactly LAT cycles
        read_burst(9, 1, 1'b0);
        drain();
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/amm_mem_slave.md
# amm_mem_slave

Avalon-MM burst slave with a byte-enabled internal memory. It answers the read, write and write-and-check traffic generated by the memory checker's master side. It is the responder end of the checker's AMM interface: it is instantiated in simulation and bring-up builds in place of the external memory controller. It is fully deterministic, with configurable read latency, so checker statistics (ticks, delays, error address/data) are predictable.

## Interface
Parameters:
- AMM_ADDR_W, 32, byte address width (rtl_settings_pkg value)
- AMM_DATA_W, 512, data width; DATA_B_W = AMM_DATA_W/8, ADDR_B_W = log2(DATA_B_W)
- AMM_BURST_W, 11, burstcount width
- MEM_DEPTH_W, 10, log2 of memory depth in AMM words
- RD_LATENCY, 2, cycles from read issue to readdatavalid, minimum 1

Ports:
- clk_i, in, 1, clock
- rst_i, in, 1, asynchronous active-high reset
- amm_address_i, in, AMM_ADDR_W, byte address; only bits [ADDR_B_W +: MEM_DEPTH_W] are used
- amm_read_i, in, 1, read request
- amm_write_i, in, 1, write request/beat
- amm_writedata_i, in, AMM_DATA_W, write data
- amm_byteenable_i, in, DATA_B_W, byte lane enables
- amm_burstcount_i, in, AMM_BURST_W, words in burst; 0 is treated as 1
- amm_waitrequest_o, out, 1, slave stall
- amm_readdata_o, out, AMM_DATA_W, read data
- amm_readdatavalid_o, out, 1, read data valid
- wr_words_o, out, 32, accepted write beats, saturating
- rd_words_o, out, 32, returned read words, saturating
- protocol_err_o, out, 1, sticky illegal-request flag

## Operation
- States: IDLE, WR_BURST, RD_BURST.
- IDLE, write=1: capture the word index and burstcount N, then write beat 0.
  - N=1: stay in IDLE.
  - N>1: go to WR_BURST with beats_left=N-1.
- IDLE, read=1 and write=0: capture the word index and N, then issue internal read 0.
  - N=1: stay in IDLE.
  - N>1: go to RD_BURST with words_left=N-1.
- IDLE, read=1 and write=1: the write is accepted, the read is dropped, and protocol_err_o is set.
- WR_BURST: waitrequest is low.
  - Each write=1 cycle stores a beat at the next index and decrements beats_left.
  - Return to IDLE after the last beat.
  - Cycles with write=0 are idle.
  - read=1 in WR_BURST is ignored and sets protocol_err_o.
- RD_BURST: waitrequest is high. One internal read issues per cycle at successive indexes. Return to IDLE after the last issue.
- Address increment is modulo 2^MEM_DEPTH_W. A burst crossing the top wraps to index 0.
- Writes update only the lanes whose byteenable bit is 1. Other lanes keep their contents.
- Memory contents are not reset and are undefined until written.
- wr_words_o increments per accepted beat. rd_words_o increments per readdatavalid. Both saturate at 0xFFFF_FFFF.
- protocol_err_o clears only on rst_i.

## Timing
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, wr_words=0, rd_words=0, protocol_err=0, state=IDLE, read pipeline flushed.
- waitrequest falls in the first clock after rst_i deasserts.
- A read command accepted at cycle T with burstcount N:
  - issues at T..T+N-1;
  - readdatavalid is high at T+RD_LATENCY..T+RD_LATENCY+N-1, contiguous;
  - waitrequest is high T+1..T+N-1 and low at T+N.
- A new command may be accepted at T+N while earlier read data is still in the pipeline. Data returns strictly in order.
- A write beat at cycle T is visible to a read issued at T+1 or later.
- The memory read port is registered (1 cycle). RD_LATENCY-1 further pipeline stages carry data and valid.
- readdata holds its last value when readdatavalid=0.
- rst_i mid-burst: the burst is aborted, the pipeline is flushed, and no readdatavalid is produced for reads issued before reset.

## Structure
- Shared package rtl_settings_pkg receives:
  - typedef enum amm_slave_state_t {IDLE, WR_BURST, RD_BURST};
  - constant AMM_SLAVE_RD_LATENCY = 2;
  - AMM widths, DATA_B_W and ADDR_B_W are reused from the package.
- One sub-module, amm_slave_ram: a single-port, DATA_B_W-lane byte-enabled RAM with a registered read output. It infers block RAM.
- Top level holds the FSM, burst counters, latency shift register and statistic counters.

## Test plan
- Reset release → waitrequest=1 during reset, 0 one cycle later; all other outputs 0.
- Write burst at address 0x40, N=4, data words 0xA0..0xA3 with all lanes enabled, then read burst at 0x40, N=4, RD_LATENCY=2 → waitrequest high for 3 cycles after the read; 4 contiguous valids starting 2 cycles after acceptance; data A0..A3 in order; wr_words=4, rd_words=4.
- Write 0xFF in every byte of word 5, then write 0x00 to word 5 with byteenable=0x1 → read returns byte0=0x00 and all other bytes 0xFF.
- MEM_DEPTH_W=4, write burst of 3 words starting at word 15 → data lands at words 15, 0, 1; a read burst of 3 from word 15 returns it identically.
- read=1 and write=1 asserted together in IDLE → write stored, no readdatavalid, protocol_err_o=1 and it remains 1 until rst_i.
- Read burst N=8 with rst_i asserted at acceptance+3 → readdatavalid stays 0 after reset and rd_words=0; a subsequent single read returns valid data in exactly RD_LATENCY cycles.
